// File: rtl/leve1_pkg.sv
// Shared LEVE1 pipeline definitions: widths, NOP encoding, opcodes, instruction field helpers
// and the ID->EX payload.
package leve1_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned RIDX_W = 5;

    // ADDI x0,x0,0 drives EX on reset and on bubbles
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [RIDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xword_t;
    typedef logic [ILEN-1:0]   instr_t;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    typedef struct packed {
        logic   valid;
        xword_t pc;
        instr_t instr;
        xword_t rs1;
        xword_t rs2;
    } id_ex_t;

    function automatic reg_idx_t rs1(input instr_t instr);
        return instr[19:15];
    endfunction

    function automatic reg_idx_t rs2(input instr_t instr);
        return instr[24:20];
    endfunction

    function automatic reg_idx_t rd(input instr_t instr);
        return instr[11:7];
    endfunction

    function automatic logic [6:0] opcode(input instr_t instr);
        return instr[6:0];
    endfunction

    // A producer hits a source when it writes a matching non-zero register
    function automatic logic src_hit(input logic valid, input logic we,
                                     input reg_idx_t dst, input reg_idx_t src);
        return valid && we && (src != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/leve1_regfile.sv
// Integer register file, two read ports and one write port.
// x0 is hardwired to zero; a same-cycle write is visible on the read ports.
module leve1_regfile
    import leve1_pkg::*;
(
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                we,
    input  logic [RIDX_W-1:0]   waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [RIDX_W-1:0]   raddr1,
    input  logic [RIDX_W-1:0]   raddr2,
    output logic [XLEN-1:0]     rdata1_c,
    output logic [XLEN-1:0]     rdata2_c
);

    xword_t regs [NREG];
    logic   wr_en_c;

    assign wr_en_c = we && (waddr != '0);

    // Entry 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            regs <= '{default: '0};
        end else if (wr_en_c) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1_c = regs[raddr1];
        if (raddr1 == '0) begin
            rdata1_c = '0;
        end else if (wr_en_c && (waddr == raddr1)) begin
            rdata1_c = wdata;
        end
    end

    always_comb begin
        rdata2_c = regs[raddr2];
        if (raddr2 == '0) begin
            rdata2_c = '0;
        end else if (wr_en_c && (waddr == raddr2)) begin
            rdata2_c = wdata;
        end
    end

endmodule

// File: rtl/leve1_id.sv
// LEVE1 decode/register-read stage: operand fetch, RAW resolution against EX/WB, ID->EX register.
// LEVE1_ID_EX_FWD_EN selects the EX bypass path; without it an EX hazard stalls one cycle.
module leve1_id
    import leve1_pkg::*;
(
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                IVALID,
    output logic                IREADY,
    input  logic [XLEN-1:0]     IPC,
    input  logic [ILEN-1:0]     IINSTR,
    input  logic                FLUSH,
    input  logic                EX_VALID,
    input  logic                EX_WE,
    input  logic [RIDX_W-1:0]   EX_RD_IDX,
    input  logic [XLEN-1:0]     EX_FWD_RD,
    input  logic                WB_VALID,
    input  logic                WB_WE,
    input  logic [RIDX_W-1:0]   WB_RD_IDX,
    input  logic [XLEN-1:0]     WB_RD,
    output logic                OVALID,
    output logic [XLEN-1:0]     OPC,
    output logic [ILEN-1:0]     OINSTR,
    output logic [XLEN-1:0]     ORS1,
    output logic [XLEN-1:0]     ORS2
);

    reg_idx_t rs1_idx_c;
    reg_idx_t rs2_idx_c;
    xword_t   rf_rs1_c;
    xword_t   rf_rs2_c;
    xword_t   opnd1_c;
    xword_t   opnd2_c;
    logic     wb_wr_c;
    logic     ex_hit1_c;
    logic     ex_hit2_c;
    logic     wb_hit1_c;
    logic     wb_hit2_c;
    logic     stall_c;
    logic     accept_c;
    id_ex_t   out_q;

    assign rs1_idx_c = rs1(IINSTR);
    assign rs2_idx_c = rs2(IINSTR);
    assign wb_wr_c   = WB_VALID && WB_WE;

    leve1_regfile u_regfile (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .we       (wb_wr_c),
        .waddr    (WB_RD_IDX),
        .wdata    (WB_RD),
        .raddr1   (rs1_idx_c),
        .raddr2   (rs2_idx_c),
        .rdata1_c (rf_rs1_c),
        .rdata2_c (rf_rs2_c)
    );

    // Both source fields are checked regardless of opcode
    assign ex_hit1_c = src_hit(EX_VALID, EX_WE, EX_RD_IDX, rs1_idx_c);
    assign ex_hit2_c = src_hit(EX_VALID, EX_WE, EX_RD_IDX, rs2_idx_c);
    assign wb_hit1_c = src_hit(WB_VALID, WB_WE, WB_RD_IDX, rs1_idx_c);
    assign wb_hit2_c = src_hit(WB_VALID, WB_WE, WB_RD_IDX, rs2_idx_c);

`ifdef LEVE1_ID_EX_FWD_EN
    assign stall_c = 1'b0;
`else
    // The EX producer reaches WB next cycle, where WB forwarding covers it
    assign stall_c = IVALID && (ex_hit1_c || ex_hit2_c) && !FLUSH;

    logic unused_ex_fwd;
    assign unused_ex_fwd = ^EX_FWD_RD;
`endif

    assign IREADY   = !stall_c;
    assign accept_c = IVALID && !stall_c && !FLUSH;

    // Operand priority: x0, then EX bypass, then WB bypass, then register file
    always_comb begin
        opnd1_c = rf_rs1_c;
        if (rs1_idx_c == '0) begin
            opnd1_c = '0;
`ifdef LEVE1_ID_EX_FWD_EN
        end else if (ex_hit1_c) begin
            opnd1_c = EX_FWD_RD;
`endif
        end else if (wb_hit1_c) begin
            opnd1_c = WB_RD;
        end
    end

    always_comb begin
        opnd2_c = rf_rs2_c;
        if (rs2_idx_c == '0) begin
            opnd2_c = '0;
`ifdef LEVE1_ID_EX_FWD_EN
        end else if (ex_hit2_c) begin
            opnd2_c = EX_FWD_RD;
`endif
        end else if (wb_hit2_c) begin
            opnd2_c = WB_RD;
        end
    end

    // Bubbles clear valid and the instruction; PC and operands keep their last values
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            out_q.valid <= 1'b0;
            out_q.pc    <= '0;
            out_q.instr <= NOP_INSTR;
            out_q.rs1   <= '0;
            out_q.rs2   <= '0;
        end else if (accept_c) begin
            out_q.valid <= 1'b1;
            out_q.pc    <= IPC;
            out_q.instr <= IINSTR;
            out_q.rs1   <= opnd1_c;
            out_q.rs2   <= opnd2_c;
        end else begin
            out_q.valid <= 1'b0;
            out_q.instr <= NOP_INSTR;
        end
    end

    assign OVALID = out_q.valid;
    assign OPC    = out_q.pc;
    assign OINSTR = out_q.instr;
    assign ORS1   = out_q.rs1;
    assign ORS2   = out_q.rs2;

endmodule

// File: tb/tb_leve1_id.sv
// Self-checking bench for leve1_id: directed vector table, hand-written hazard sequences and
// randomized traffic against a register-array reference model.
module tb_leve1_id;

`ifdef LEVE1_ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [63:0] DB  = 64'hDEAD_BEEF;

    logic        CLK, RSTn, IVALID, IREADY, FLUSH;
    logic        EX_VALID, EX_WE, WB_VALID, WB_WE, OVALID;
    logic [63:0] IPC, EX_FWD_RD, WB_RD, OPC, ORS1, ORS2;
    logic [31:0] IINSTR, OINSTR;
    logic [4:0]  EX_RD_IDX, WB_RD_IDX;

    int n_checks = 0;
    int n_errors = 0;

    leve1_id dut (
        .CLK(CLK), .RSTn(RSTn), .IVALID(IVALID), .IREADY(IREADY), .IPC(IPC), .IINSTR(IINSTR),
        .FLUSH(FLUSH), .EX_VALID(EX_VALID), .EX_WE(EX_WE), .EX_RD_IDX(EX_RD_IDX),
        .EX_FWD_RD(EX_FWD_RD), .WB_VALID(WB_VALID), .WB_WE(WB_WE), .WB_RD_IDX(WB_RD_IDX),
        .WB_RD(WB_RD), .OVALID(OVALID), .OPC(OPC), .OINSTR(OINSTR), .ORS1(ORS1), .ORS2(ORS2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iv, fl;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        wv, wwe;
        logic [4:0]  widx;
        logic [63:0] wd;
        logic        ev, ewe;
        logic [4:0]  eidx;
        logic [63:0] ed;
        logic        x_rdy, x_ov;
        logic [63:0] x_pc;
        logic [31:0] x_ins;
        logic [63:0] x_rs1, x_rs2;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] s1,
                                           input logic [4:0] s2);
        return {7'b0, s2, s1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] s1,
                                         input logic [11:0] imm);
        return {imm, s1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic vec_t mk(input logic iv, input logic fl, input logic [63:0] pc,
                                input logic [31:0] ins, input logic wv, input logic wwe,
                                input logic [4:0] widx, input logic [63:0] wd,
                                input logic ev, input logic ewe, input logic [4:0] eidx,
                                input logic [63:0] ed, input logic rdy, input logic ov,
                                input logic [63:0] xpc, input logic [31:0] xins,
                                input logic [63:0] x1, input logic [63:0] x2);
        vec_t v;
        v.iv = iv; v.fl = fl; v.pc = pc; v.ins = ins;
        v.wv = wv; v.wwe = wwe; v.widx = widx; v.wd = wd;
        v.ev = ev; v.ewe = ewe; v.eidx = eidx; v.ed = ed;
        v.x_rdy = rdy; v.x_ov = ov; v.x_pc = xpc; v.x_ins = xins; v.x_rs1 = x1; v.x_rs2 = x2;
        return v;
    endfunction

    task automatic idle();
        IVALID = 1'b0; FLUSH = 1'b0; IPC = '0; IINSTR = NOP;
        EX_VALID = 1'b0; EX_WE = 1'b0; EX_RD_IDX = '0; EX_FWD_RD = '0;
        WB_VALID = 1'b0; WB_WE = 1'b0; WB_RD_IDX = '0; WB_RD = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model state: architectural registers plus the ID->EX register
    logic [63:0] m_rf [32];
    logic        m_ov;
    logic [63:0] m_pc, m_rs1, m_rs2;
    logic [31:0] m_ins;

    function automatic logic m_ex_hit(input logic [4:0] r);
        return (r != 0) && EX_VALID && EX_WE && (EX_RD_IDX == r);
    endfunction

    function automatic logic [63:0] m_opnd(input logic [4:0] r);
        if (r == 0) return 64'd0;
        if (FWD && m_ex_hit(r)) return EX_FWD_RD;
        if (WB_VALID && WB_WE && (WB_RD_IDX == r)) return WB_RD;
        return m_rf[r];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_ov = 1'b0; m_pc = '0; m_ins = NOP; m_rs1 = '0; m_rs2 = '0;
    endtask

    initial begin
        logic        exp_rdy, acc, ex_v, wb_v, stall;
        logic [63:0] ex_val, wb_val;
        int          issued, bubbles;
        logic [4:0]  s1, s2;
        logic [31:0] ins;

        // Reset with a fetch beat presented
        idle();
        RSTn = 1'b0; IVALID = 1'b1; IINSTR = r_type(1, 2, 3); IPC = 64'h40;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ovalid", 64'(OVALID), 64'd0);
        chk("rst_opc", OPC, 64'd0);
        chk("rst_oinstr", 64'(OINSTR), 64'(NOP));
        chk("rst_ors1", ORS1, 64'd0);
        chk("rst_ors2", ORS2, 64'd0);
        chk("rst_iready", 64'(IREADY), 64'd1);
        RSTn = 1'b1;

        for (int i = 1; i < 32; i++) begin
            idle();
            IVALID = 1'b1; IINSTR = r_type(5'd0, 5'(i), 5'(i)); IPC = 64'(i * 4);
            tick();
            chk($sformatf("rf_clear_x%0d", i), ORS1 | ORS2, 64'd0);
        end

        // Four dependent addi x1,x1,1 beats with a bench-side EX/WB pipeline
        idle();
        issued = 0; bubbles = 0; ex_v = 1'b0; wb_v = 1'b0; ex_val = '0; wb_val = '0;
        for (int c = 0; c < 20 && issued < 4; c++) begin
            IVALID = 1'b1; IINSTR = addi(5'd1, 5'd1, 12'd1); IPC = 64'h300 + 64'(4 * issued);
            EX_VALID = ex_v; EX_WE = 1'b1; EX_RD_IDX = 5'd1; EX_FWD_RD = ex_val;
            WB_VALID = wb_v; WB_WE = 1'b1; WB_RD_IDX = 5'd1; WB_RD = wb_val;
            #1;
            exp_rdy = FWD ? 1'b1 : !ex_v;
            chk("b2b_iready", 64'(IREADY), 64'(exp_rdy));
            acc = exp_rdy;
            tick();
            wb_v = ex_v; wb_val = ex_val;
            if (acc) begin
                chk("b2b_ovalid", 64'(OVALID), 64'd1);
                chk("b2b_ors1", ORS1, 64'(issued));
                ex_v = 1'b1; ex_val = 64'(issued + 1);
                issued++;
            end else begin
                chk("b2b_bubble_ovalid", 64'(OVALID), 64'd0);
                ex_v = 1'b0;
                bubbles++;
            end
        end
        chk("b2b_issued", 64'(issued), 64'd4);
        chk("b2b_bubbles", 64'(bubbles), FWD ? 64'd0 : 64'd3);
        for (int c = 0; c < 2; c++) begin
            IVALID = 1'b0;
            EX_VALID = ex_v; EX_FWD_RD = ex_val; WB_VALID = wb_v; WB_RD = wb_val;
            tick();
            wb_v = ex_v; wb_val = ex_val; ex_v = 1'b0;
        end

        // Directed vectors: write-through, holds on bubbles, flush, x0 protection, no-hazard EX
        tbl.push_back(mk(1,0,64'h100,r_type(6,5,0), 1,1,5,DB,     0,0,0,0,          1,1,64'h100,r_type(6,5,0),DB,0));
        tbl.push_back(mk(0,0,64'h104,r_type(6,5,0), 0,0,0,0,      0,0,0,0,          1,0,64'h100,NOP,DB,0));
        tbl.push_back(mk(1,0,64'h108,r_type(7,5,5), 0,0,0,0,      0,0,0,0,          1,1,64'h108,r_type(7,5,5),DB,DB));
        tbl.push_back(mk(1,1,64'h080,r_type(1,2,3), 0,0,0,0,      0,0,0,0,          1,0,64'h108,NOP,DB,DB));
        tbl.push_back(mk(1,0,64'h10C,r_type(1,0,0), 1,1,0,'1,     0,0,0,0,          1,1,64'h10C,r_type(1,0,0),0,0));
        tbl.push_back(mk(1,0,64'h110,r_type(1,0,0), 0,0,0,0,      0,0,0,0,          1,1,64'h110,r_type(1,0,0),0,0));
        tbl.push_back(mk(1,0,64'h114,r_type(4,3,5), 0,1,3,64'h55, 0,0,0,0,          1,1,64'h114,r_type(4,3,5),0,DB));
        tbl.push_back(mk(1,0,64'h118,r_type(4,3,5), 0,0,0,0,      0,0,0,0,          1,1,64'h118,r_type(4,3,5),0,DB));
        tbl.push_back(mk(1,0,64'h11C,r_type(4,3,5), 1,0,3,64'h77, 0,0,0,0,          1,1,64'h11C,r_type(4,3,5),0,DB));
        tbl.push_back(mk(1,0,64'h120,r_type(1,0,0), 0,0,0,0,      1,1,0,64'hAAAA,   1,1,64'h120,r_type(1,0,0),0,0));
        tbl.push_back(mk(1,0,64'h124,r_type(7,5,5), 0,0,0,0,      1,0,5,64'h99,     1,1,64'h124,r_type(7,5,5),DB,DB));
        tbl.push_back(mk(1,0,64'h128,r_type(7,5,5), 0,0,0,0,      0,1,5,64'h99,     1,1,64'h128,r_type(7,5,5),DB,DB));
        tbl.push_back(mk(1,0,64'h12C,r_type(7,5,5), 1,1,5,64'h5555,0,0,0,0,         1,1,64'h12C,r_type(7,5,5),64'h5555,64'h5555));

        foreach (tbl[k]) begin
            IVALID = tbl[k].iv; FLUSH = tbl[k].fl; IPC = tbl[k].pc; IINSTR = tbl[k].ins;
            WB_VALID = tbl[k].wv; WB_WE = tbl[k].wwe; WB_RD_IDX = tbl[k].widx; WB_RD = tbl[k].wd;
            EX_VALID = tbl[k].ev; EX_WE = tbl[k].ewe; EX_RD_IDX = tbl[k].eidx; EX_FWD_RD = tbl[k].ed;
            #1;
            chk($sformatf("tbl%0d_iready", k), 64'(IREADY), 64'(tbl[k].x_rdy));
            tick();
            chk($sformatf("tbl%0d_ovalid", k), 64'(OVALID), 64'(tbl[k].x_ov));
            chk($sformatf("tbl%0d_opc", k), OPC, tbl[k].x_pc);
            chk($sformatf("tbl%0d_oinstr", k), 64'(OINSTR), 64'(tbl[k].x_ins));
            chk($sformatf("tbl%0d_ors1", k), ORS1, tbl[k].x_rs1);
            chk($sformatf("tbl%0d_ors2", k), ORS2, tbl[k].x_rs2);
        end

        // EX hazard on x7: bypass, or one stall then WB forwarding
        idle();
        IVALID = 1'b1; IPC = 64'h200; IINSTR = addi(5'd8, 5'd7, 12'd1);
        EX_VALID = 1'b1; EX_WE = 1'b1; EX_RD_IDX = 5'd7; EX_FWD_RD = 64'h1234;
        #1;
        chk("exhaz_iready", 64'(IREADY), FWD ? 64'd1 : 64'd0);
        tick();
        chk("exhaz_ovalid", 64'(OVALID), FWD ? 64'd1 : 64'd0);
        chk("exhaz_ors1", ORS1, FWD ? 64'h1234 : 64'h5555);
        chk("exhaz_opc", OPC, FWD ? 64'h200 : 64'h12C);
        EX_VALID = 1'b0;
        WB_VALID = 1'b1; WB_WE = 1'b1; WB_RD_IDX = 5'd7; WB_RD = 64'h1234;
        IVALID = !FWD;
        #1;
        chk("exhaz_wb_iready", 64'(IREADY), 64'd1);
        tick();
        chk("exhaz_wb_ovalid", 64'(OVALID), FWD ? 64'd0 : 64'd1);
        chk("exhaz_wb_ors1", ORS1, 64'h1234);
        chk("exhaz_wb_opc", OPC, 64'h200);

        // Flush arriving while the hazard holds the beat
        idle();
        IVALID = 1'b1; IPC = 64'h204; IINSTR = addi(5'd8, 5'd7, 12'd1);
        EX_VALID = 1'b1; EX_WE = 1'b1; EX_RD_IDX = 5'd7; EX_FWD_RD = 64'h4321;
        #1;
        chk("flst_iready", 64'(IREADY), FWD ? 64'd1 : 64'd0);
        tick();
        FLUSH = 1'b1;
        #1;
        chk("flst_flush_iready", 64'(IREADY), 64'd1);
        tick();
        chk("flst_ovalid", 64'(OVALID), 64'd0);
        chk("flst_oinstr", 64'(OINSTR), 64'(NOP));
        chk("flst_opc", OPC, FWD ? 64'h204 : 64'h200);

        // Randomized traffic against the reference model, with occasional async reset
        idle();
        RSTn = 1'b0;
        #1;
        RSTn = 1'b1;
        m_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                RSTn = 1'b0;
                #1;
                chk("rnd_rst_ovalid", 64'(OVALID), 64'd0);
                chk("rnd_rst_oinstr", 64'(OINSTR), 64'(NOP));
                chk("rnd_rst_ors1", ORS1, 64'd0);
                RSTn = 1'b1;
                m_reset();
            end
            ins = $urandom();
            s1 = 5'($urandom_range(0, 3));
            s2 = 5'($urandom_range(0, 3));
            ins[19:15] = s1;
            ins[24:20] = s2;
            IVALID    = ($urandom_range(0, 3) != 0);
            FLUSH     = ($urandom_range(0, 9) == 0);
            IPC       = {$urandom(), $urandom()};
            IINSTR    = ins;
            EX_VALID  = 1'($urandom_range(0, 1));
            EX_WE     = 1'($urandom_range(0, 1));
            EX_RD_IDX = 5'($urandom_range(0, 3));
            EX_FWD_RD = {$urandom(), $urandom()};
            WB_VALID  = 1'($urandom_range(0, 1));
            WB_WE     = 1'($urandom_range(0, 1));
            WB_RD_IDX = 5'($urandom_range(0, 3));
            WB_RD     = {$urandom(), $urandom()};
            #1;
            stall = !FWD && IVALID && (m_ex_hit(s1) || m_ex_hit(s2)) && !FLUSH;
            chk("rnd_iready", 64'(IREADY), 64'(!stall));
            if (IVALID && !stall && !FLUSH) begin
                m_ov = 1'b1; m_pc = IPC; m_ins = ins; m_rs1 = m_opnd(s1); m_rs2 = m_opnd(s2);
            end else begin
                m_ov = 1'b0; m_ins = NOP;
            end
            if (WB_VALID && WB_WE && (WB_RD_IDX != 0)) m_rf[WB_RD_IDX] = WB_RD;
            tick();
            chk("rnd_ovalid", 64'(OVALID), 64'(m_ov));
            chk("rnd_opc", OPC, m_pc);
            chk("rnd_oinstr", 64'(OINSTR), 64'(m_ins));
            chk("rnd_ors1", ORS1, m_rs1);
            chk("rnd_ors2", ORS2, m_rs2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
